// File: rtl/mini_src_pkg.sv
// Shared constants for the Mini-SRC control path: opcodes, sequencer state codes
// and the instruction classes that pick the execute-phase strobe pattern.
package mini_src_pkg;

   localparam int OPCODE_W = 5;

   localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00011;
   localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00100;
   localparam logic [OPCODE_W-1:0] OP_AND  = 5'b01001;
   localparam logic [OPCODE_W-1:0] OP_OR   = 5'b01010;
   localparam logic [OPCODE_W-1:0] OP_MUL  = 5'b01110;
   localparam logic [OPCODE_W-1:0] OP_DIV  = 5'b01111;
   localparam logic [OPCODE_W-1:0] OP_NEG  = 5'b10000;
   localparam logic [OPCODE_W-1:0] OP_NOT  = 5'b10001;
   localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b11010;
   localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11011;

   localparam logic [3:0] S_RST  = 4'd0;
   localparam logic [3:0] S_T0   = 4'd1;
   localparam logic [3:0] S_T1   = 4'd2;
   localparam logic [3:0] S_T2   = 4'd3;
   localparam logic [3:0] S_T3   = 4'd4;
   localparam logic [3:0] S_T4   = 4'd5;
   localparam logic [3:0] S_T5   = 4'd6;
   localparam logic [3:0] S_T6   = 4'd7;
   localparam logic [3:0] S_HALT = 4'd8;

   typedef enum logic [2:0] {
      CLS_ALU3   = 3'd0,
      CLS_MULDIV = 3'd1,
      CLS_UNARY  = 3'd2,
      CLS_NOP    = 3'd3,
      CLS_HALT   = 3'd4,
      CLS_ILL    = 3'd5
   } op_class_t;

endpackage

// File: rtl/opcode_classify.sv
// Maps an opcode onto its execution class; anything not recognised is flagged illegal.
module opcode_classify
   import mini_src_pkg::*;
(
   input  logic [OPCODE_W-1:0] opcode,
   output op_class_t           op_class,
   output logic                illegal
);

   always_comb begin
      op_class = CLS_ILL;
      case (opcode)
         OP_ADD, OP_SUB, OP_AND, OP_OR: op_class = CLS_ALU3;
         OP_MUL, OP_DIV:                op_class = CLS_MULDIV;
         OP_NEG, OP_NOT:                op_class = CLS_UNARY;
         OP_NOP:                        op_class = CLS_NOP;
         OP_HALT:                       op_class = CLS_HALT;
         default:                       op_class = CLS_ILL;
      endcase
      illegal = (op_class == CLS_ILL);
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Mini-SRC control unit: fetch T0-T2, decode in T3, class-specific execute
// cycles, then back to T0 (or HALT when a stop is pending).
//
// state | meaning
// RST   | post-clear, all strobes idle
// T0    | PC -> MAR, PC+1 -> Z
// T1    | Z -> PC, memory read into MDR
// T2    | MDR -> IR
// T3-T6 | execute cycles, pattern chosen by opcode class
// HALT  | stopped, run=0, left only by clear
module control_sequencer
   import mini_src_pkg::*;
#(
   parameter int OP_W = OPCODE_W
)(
   input  logic            Clock,
   input  logic            clear,
   input  logic [31:0]     IR,
   input  logic            stop,
   output logic            PCout,
   output logic            Zlowout,
   output logic            Zhighout,
   output logic            MDRout,
   output logic            Rout,
   output logic            MARin,
   output logic            Zin,
   output logic            PCin,
   output logic            MDRin,
   output logic            IRin,
   output logic            Yin,
   output logic            LOin,
   output logic            HIin,
   output logic            Rin,
   output logic            Gra,
   output logic            Grb,
   output logic            Grc,
   output logic            IncPC,
   output logic            Read,
   output logic [OP_W-1:0] alu_op,
   output logic            run,
   output logic            illegal
);

   logic [3:0]      state, state_nxt, fin_state;
   op_class_t       cls_dec, cls_q, cls;
   logic [OP_W-1:0] op_q, op;
   logic            dec_ill;
   logic            stop_pend;
   logic            unused_ir;

   assign unused_ir = ^IR[31-OP_W:0];

   opcode_classify u_classify (
      .opcode   (IR[31 -: OPCODE_W]),
      .op_class (cls_dec),
      .illegal  (dec_ill)
   );

   // IR is only trusted in T3, so T3 decodes live and later states use the latched copy
   assign cls       = (state == S_T3) ? cls_dec : cls_q;
   assign op        = (state == S_T3) ? IR[31 -: OP_W] : op_q;
   assign fin_state = (stop_pend || stop) ? S_HALT : S_T0;

   always_comb begin
      state_nxt = S_RST;
      case (state)
         S_RST:  state_nxt = S_T0;
         S_T0:   state_nxt = S_T1;
         S_T1:   state_nxt = S_T2;
         S_T2:   state_nxt = S_T3;
         S_T3:
            case (cls)
               CLS_ALU3, CLS_MULDIV, CLS_UNARY: state_nxt = S_T4;
               CLS_HALT:                        state_nxt = S_HALT;
               default:                         state_nxt = fin_state;
            endcase
         S_T4:   state_nxt = (cls == CLS_UNARY) ? fin_state : S_T5;
         S_T5:   state_nxt = (cls == CLS_MULDIV) ? S_T6 : fin_state;
         S_T6:   state_nxt = fin_state;
         S_HALT: state_nxt = S_HALT;
         default: state_nxt = S_RST;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (clear) begin
         state     <= S_RST;
         cls_q     <= CLS_NOP;
         op_q      <= '0;
         stop_pend <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == S_T3) begin
            cls_q <= cls_dec;
            op_q  <= IR[31 -: OP_W];
            if (dec_ill) illegal <= 1'b1;
         end
         if (state_nxt == S_HALT)
            stop_pend <= 1'b0;
         else if (stop && state != S_HALT)
            stop_pend <= 1'b1;
      end
   end

   always_comb begin
      PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0; Rout = 1'b0;
      MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
      Yin = 1'b0; LOin = 1'b0; HIin = 1'b0; Rin = 1'b0;
      Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; IncPC = 1'b0; Read = 1'b0;
      alu_op = '0;
      run = (state != S_HALT);
      case (state)
         S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
         S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
         S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
         S_T3:
            case (cls)
               CLS_ALU3:   begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
               CLS_MULDIV: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
               CLS_UNARY:  begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op; end
               default: ;
            endcase
         S_T4:
            case (cls)
               CLS_ALU3:   begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op; end
               CLS_MULDIV: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op; end
               CLS_UNARY:  begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               default: ;
            endcase
         S_T5:
            case (cls)
               CLS_ALU3:   begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               CLS_MULDIV: begin Zlowout = 1'b1; LOin = 1'b1; end
               default: ;
            endcase
         S_T6:
            if (cls == CLS_MULDIV) begin
               Zhighout = 1'b1; HIin = 1'b1;
            end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks fetch/execute for each class, halt, stop and clear.
module tb_control_sequencer;

   logic        Clock = 1'b0;
   logic        clear = 1'b1;
   logic [31:0] IR    = 32'h0;
   logic        stop  = 1'b0;
   logic PCout, Zlowout, Zhighout, MDRout, Rout, MARin, Zin, PCin, MDRin, IRin;
   logic Yin, LOin, HIin, Rin, Gra, Grb, Grc, IncPC, Read;
   logic [4:0] alu_op;
   logic run, illegal;

   int errors = 0;
   int checks = 0;
   logic ill_exp = 1'b0;

   localparam logic [18:0] B_PCOUT = 19'd1 << 18;
   localparam logic [18:0] B_ZLOW  = 19'd1 << 17;
   localparam logic [18:0] B_ZHIGH = 19'd1 << 16;
   localparam logic [18:0] B_MDROUT= 19'd1 << 15;
   localparam logic [18:0] B_ROUT  = 19'd1 << 14;
   localparam logic [18:0] B_MARIN = 19'd1 << 13;
   localparam logic [18:0] B_ZIN   = 19'd1 << 12;
   localparam logic [18:0] B_PCIN  = 19'd1 << 11;
   localparam logic [18:0] B_MDRIN = 19'd1 << 10;
   localparam logic [18:0] B_IRIN  = 19'd1 << 9;
   localparam logic [18:0] B_YIN   = 19'd1 << 8;
   localparam logic [18:0] B_LOIN  = 19'd1 << 7;
   localparam logic [18:0] B_HIIN  = 19'd1 << 6;
   localparam logic [18:0] B_RIN   = 19'd1 << 5;
   localparam logic [18:0] B_GRA   = 19'd1 << 4;
   localparam logic [18:0] B_GRB   = 19'd1 << 3;
   localparam logic [18:0] B_GRC   = 19'd1 << 2;
   localparam logic [18:0] B_INCPC = 19'd1 << 1;
   localparam logic [18:0] B_READ  = 19'd1 << 0;

   localparam logic [18:0] E_NONE = 19'd0;
   localparam logic [18:0] E_T0 = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
   localparam logic [18:0] E_T1 = B_ZLOW | B_PCIN | B_READ | B_MDRIN;
   localparam logic [18:0] E_T2 = B_MDROUT | B_IRIN;

   logic [18:0] strobes;
   assign strobes = {PCout, Zlowout, Zhighout, MDRout, Rout, MARin, Zin, PCin, MDRin, IRin,
                     Yin, LOin, HIin, Rin, Gra, Grb, Grc, IncPC, Read};

   control_sequencer dut (
      .Clock(Clock), .clear(clear), .IR(IR), .stop(stop),
      .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout), .Rout(Rout),
      .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
      .Yin(Yin), .LOin(LOin), .HIin(HIin), .Rin(Rin),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read),
      .alu_op(alu_op), .run(run), .illegal(illegal)
   );

   always #5 Clock = ~Clock;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [18:0] exp_s, input logic [4:0] exp_op,
                        input logic exp_run);
      checks++;
      assert (strobes === exp_s) else begin
         errors++;
         $error("FAIL %s strobes got %05h want %05h", tag, strobes, exp_s);
      end
      checks++;
      assert (alu_op === exp_op) else begin
         errors++;
         $error("FAIL %s alu_op got %05b want %05b", tag, alu_op, exp_op);
      end
      checks++;
      assert (run === exp_run) else begin
         errors++;
         $error("FAIL %s run got %b want %b", tag, run, exp_run);
      end
      checks++;
      assert (illegal === ill_exp) else begin
         errors++;
         $error("FAIL %s illegal got %b want %b", tag, illegal, ill_exp);
      end
   endtask

   // Entered with the DUT in T0; leaves it in T3 with IR loaded.
   task automatic fetch(input string tag, input logic [31:0] ir, input logic stop_t1);
      check({tag, "_t0"}, E_T0, 5'd0, 1'b1);
      tick();
      stop = stop_t1;
      IR = ir;
      check({tag, "_t1"}, E_T1, 5'd0, 1'b1);
      tick();
      stop = 1'b0;
      check({tag, "_t2"}, E_T2, 5'd0, 1'b1);
      tick();
   endtask

   initial begin
      tick();
      tick();
      check("reset", E_NONE, 5'd0, 1'b1);
      clear = 1'b0;
      tick();

      // sub R1,R2,R3
      fetch("sub", 32'h20918000, 1'b0);
      check("sub_t3", B_GRB | B_ROUT | B_YIN, 5'd0, 1'b1);
      tick();
      check("sub_t4", B_GRC | B_ROUT | B_ZIN, 5'b00100, 1'b1);
      tick();
      check("sub_t5", B_ZLOW | B_GRA | B_RIN, 5'd0, 1'b1);
      tick();

      // mul R2,R3
      fetch("mul", 32'h71180000, 1'b0);
      check("mul_t3", B_GRA | B_ROUT | B_YIN, 5'd0, 1'b1);
      tick();
      check("mul_t4", B_GRB | B_ROUT | B_ZIN, 5'b01110, 1'b1);
      tick();
      check("mul_t5", B_ZLOW | B_LOIN, 5'd0, 1'b1);
      tick();
      check("mul_t6", B_ZHIGH | B_HIIN, 5'd0, 1'b1);
      tick();

      // nop, then an undefined opcode on the same short path
      fetch("nop", 32'hD0000000, 1'b0);
      check("nop_t3", E_NONE, 5'd0, 1'b1);
      tick();
      fetch("ill", 32'hF8000000, 1'b0);
      check("ill_t3", E_NONE, 5'd0, 1'b1);
      tick();
      ill_exp = 1'b1;

      // halt; stop while halted must change nothing
      fetch("halt", 32'hD8000000, 1'b0);
      check("halt_t3", E_NONE, 5'd0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         stop = (i == 5);
         tick();
         check("halted", E_NONE, 5'd0, 1'b0);
      end
      stop = 1'b0;
      clear = 1'b1;
      tick();
      ill_exp = 1'b0;
      check("halt_clr_rst", E_NONE, 5'd0, 1'b1);
      clear = 1'b0;
      tick();

      // neg with a one-cycle stop in T1: finishes, then halts
      fetch("neg", 32'h80000000, 1'b1);
      check("neg_t3", B_GRB | B_ROUT | B_ZIN, 5'b10000, 1'b1);
      tick();
      check("neg_t4", B_ZLOW | B_GRA | B_RIN, 5'd0, 1'b1);
      tick();
      check("neg_halt", E_NONE, 5'd0, 1'b0);
      clear = 1'b1;
      tick();
      check("neg_clr_rst", E_NONE, 5'd0, 1'b1);
      clear = 1'b0;
      tick();

      // add with stop pending, abandoned by clear in T4 (stop also high with clear)
      fetch("add", 32'h18000000, 1'b0);
      stop = 1'b1;
      check("add_t3", B_GRB | B_ROUT | B_YIN, 5'd0, 1'b1);
      tick();
      stop = 1'b1;
      clear = 1'b1;
      check("add_t4", B_GRC | B_ROUT | B_ZIN, 5'b00011, 1'b1);
      tick();
      stop = 1'b0;
      clear = 1'b0;
      check("add_clr_rst", E_NONE, 5'd0, 1'b1);
      tick();

      // stale stop must not halt this nop; stop in its final state halts it
      fetch("nop2", 32'hD0000000, 1'b0);
      check("nop2_t3", E_NONE, 5'd0, 1'b1);
      tick();
      fetch("nop3", 32'hD0000000, 1'b0);
      stop = 1'b1;
      check("nop3_t3", E_NONE, 5'd0, 1'b1);
      tick();
      stop = 1'b0;
      check("nop3_halt", E_NONE, 5'd0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
